// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
//   memaddr_t   : 30-bit word address
//   word_t      : 32-bit data word
//   mem_owner_t : which requester owns an outstanding memory transaction
//   mem_req_t   : one downstream request beat (address, write data, byte mask, write flag)
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 30;
  localparam int WORD_W     = 32;
  localparam int WMASK_W    = 4;

  typedef logic [MEM_ADDR_W-1:0] memaddr_t;
  typedef logic [WORD_W-1:0]     word_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } mem_owner_t;

  typedef struct packed {
    memaddr_t           addr;
    word_t              wdata;
    logic [WMASK_W-1:0] wmask;
    logic               write;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_order_fifo.sv
// Order FIFO remembering the owner of every issued-but-unanswered memory request.
// Responses return in issue order, so the head entry names the owner of the
// next response.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : append push_owner (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   full, empty : occupancy flags derived from the count register
//   head        : owner at the head of the FIFO
module mem_port_arbiter_order_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  mem_owner_t push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output mem_owner_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_owner_t       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Owner storage is data only; the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_owner;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between instruction fetch (I) and the
// load/store unit (D). D has priority, but once I has lost STARVE_LIMIT
// consecutive contested cycles it is forced to win. Requests go out through a
// single registered slot; an order FIFO tracks the owner of each outstanding
// request so in-order responses are routed back combinationally.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   i_req_* / i_resp_*      : fetch request (addr, valid/ready) and response
//   d_req_* / d_resp_*      : data request (addr, wdata, wmask, write, valid/ready)
//                             and response
//   mem_req_*               : registered downstream request slot
//   mem_resp_*              : downstream response, fanned out to the owner
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  memaddr_t           i_req_addr_i,
  input  logic               i_req_valid_i,
  output logic               i_req_ready_o,
  output memaddr_t           i_resp_addr_o,
  output word_t              i_resp_data_o,
  output logic               i_resp_valid_o,
  input  logic               i_resp_ready_i,
  input  memaddr_t           d_req_addr_i,
  input  word_t              d_req_wdata_i,
  input  logic [WMASK_W-1:0] d_req_wmask_i,
  input  logic               d_req_write_i,
  input  logic               d_req_valid_i,
  output logic               d_req_ready_o,
  output memaddr_t           d_resp_addr_o,
  output word_t              d_resp_data_o,
  output logic               d_resp_valid_o,
  input  logic               d_resp_ready_i,
  output memaddr_t           mem_req_addr_o,
  output word_t              mem_req_wdata_o,
  output logic [WMASK_W-1:0] mem_req_wmask_o,
  output logic               mem_req_write_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  input  memaddr_t           mem_resp_addr_i,
  input  word_t              mem_resp_data_i,
  input  logic               mem_resp_valid_i,
  output logic               mem_resp_ready_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                slot_free;
  logic                can_grant;
  logic                starve_hit;
  logic                grant_i;
  logic                grant_d;
  logic [STARVE_W-1:0] starve;
  mem_req_t            win_req;
  mem_req_t            req_p1;
  logic                vld_p1;
  logic                fifo_full;
  logic                fifo_empty;
  logic                resp_pop;
  mem_owner_t          head_owner;
  mem_owner_t          push_owner;

  // Grants are held off during reset so both readys read 0 while rst_ni is low.
  // A response popping this cycle does not make room: can_grant uses the
  // registered occupancy only.
  assign slot_free  = !vld_p1 || mem_req_ready_i;
  assign can_grant  = rst_ni && slot_free && !fifo_full;
  assign starve_hit = i_req_valid_i && (starve >= STARVE_W'(STARVE_LIMIT));
  assign grant_d    = can_grant && d_req_valid_i && !starve_hit;
  assign grant_i    = can_grant && i_req_valid_i && !grant_d;
  assign push_owner = grant_d ? OWNER_D : OWNER_I;

  assign i_req_ready_o = grant_i;
  assign d_req_ready_o = grant_d;

  always_comb begin
    win_req = '0;
    if (grant_d) begin
      win_req.addr  = d_req_addr_i;
      win_req.wdata = d_req_wdata_i;
      win_req.wmask = d_req_wmask_i;
      win_req.write = d_req_write_i;
    end else begin
      win_req.addr  = i_req_addr_i;
    end
  end

  // Counts consecutive cycles in which a waiting I request lost to D.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve <= '0;
    end else if (grant_i || !i_req_valid_i) begin
      starve <= '0;
    end else if (grant_d && (starve < STARVE_W'(STARVE_LIMIT))) begin
      starve <= starve + STARVE_W'(1);
    end
  end

  // ---- p0 -> p1: arbitration winner registered into the downstream slot ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else if (grant_i || grant_d) begin
      vld_p1 <= 1'b1;
      req_p1 <= win_req;
    end else if (mem_req_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign mem_req_valid_o = vld_p1;
  assign mem_req_addr_o  = req_p1.addr;
  assign mem_req_wdata_o = req_p1.wdata;
  assign mem_req_wmask_o = req_p1.wmask;
  assign mem_req_write_o = req_p1.write;

  mem_port_arbiter_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (grant_i || grant_d),
    .push_owner (push_owner),
    .pop        (resp_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head_owner)
  );

  // Responses arrive in issue order, so the FIFO head is their owner. With
  // nothing outstanding a response is neither accepted nor forwarded.
  assign mem_resp_ready_o = !fifo_empty &&
                            ((head_owner == OWNER_I) ? i_resp_ready_i : d_resp_ready_i);
  assign resp_pop         = mem_resp_valid_i && mem_resp_ready_o;
  assign i_resp_valid_o   = mem_resp_valid_i && !fifo_empty && (head_owner == OWNER_I);
  assign d_resp_valid_o   = mem_resp_valid_i && !fifo_empty && (head_owner == OWNER_D);
  assign i_resp_addr_o    = mem_resp_addr_i;
  assign i_resp_data_o    = mem_resp_data_i;
  assign d_resp_addr_o    = mem_resp_addr_i;
  assign d_resp_data_o    = mem_resp_data_i;

  stray_resp_chk : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    mem_resp_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXO  = 4;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst_ni;
  memaddr_t     i_req_addr_i;
  logic         i_req_valid_i;
  logic         i_req_ready_o;
  memaddr_t     i_resp_addr_o;
  word_t        i_resp_data_o;
  logic         i_resp_valid_o;
  logic         i_resp_ready_i;
  memaddr_t     d_req_addr_i;
  word_t        d_req_wdata_i;
  logic [3:0]   d_req_wmask_i;
  logic         d_req_write_i;
  logic         d_req_valid_i;
  logic         d_req_ready_o;
  memaddr_t     d_resp_addr_o;
  word_t        d_resp_data_o;
  logic         d_resp_valid_o;
  logic         d_resp_ready_i;
  memaddr_t     mem_req_addr_o;
  word_t        mem_req_wdata_o;
  logic [3:0]   mem_req_wmask_o;
  logic         mem_req_write_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  memaddr_t     mem_resp_addr_i;
  word_t        mem_resp_data_i;
  logic         mem_resp_valid_i;
  logic         mem_resp_ready_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .i_req_addr_i    (i_req_addr_i),
    .i_req_valid_i   (i_req_valid_i),
    .i_req_ready_o   (i_req_ready_o),
    .i_resp_addr_o   (i_resp_addr_o),
    .i_resp_data_o   (i_resp_data_o),
    .i_resp_valid_o  (i_resp_valid_o),
    .i_resp_ready_i  (i_resp_ready_i),
    .d_req_addr_i    (d_req_addr_i),
    .d_req_wdata_i   (d_req_wdata_i),
    .d_req_wmask_i   (d_req_wmask_i),
    .d_req_write_i   (d_req_write_i),
    .d_req_valid_i   (d_req_valid_i),
    .d_req_ready_o   (d_req_ready_o),
    .d_resp_addr_o   (d_resp_addr_o),
    .d_resp_data_o   (d_resp_data_o),
    .d_resp_valid_o  (d_resp_valid_o),
    .d_resp_ready_i  (d_resp_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_req_write_o (mem_req_write_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_resp_addr_i (mem_resp_addr_i),
    .mem_resp_data_i (mem_resp_data_i),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural reference: queues of outstanding transactions plus the
  // arbitration rules stated as plain conditions.
  typedef struct {
    memaddr_t addr;
    int       age;
    int       lat;
  } be_t;

  be_t      bq[$];       // accepted by memory, response not yet delivered
  bit       oq[$];       // owner of each granted, unanswered request (1 = D)
  memaddr_t i_addr_q[$]; // I addresses in grant order
  memaddr_t d_addr_q[$]; // D addresses in grant order
  bit       m_vld;
  mem_req_t m_slot;
  int       m_lost;      // consecutive contested cycles I has lost
  bit       i_acc, d_acc;

  // Stimulus knobs (percent probabilities)
  int p_i, p_d, p_mr, p_ir, p_dr, lat_max;
  bit resp_en;

  function automatic word_t rdata(input memaddr_t a);
    return {a, 2'b10} ^ 32'h3C3C_0F0F;
  endfunction

  function automatic bit coin(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic model_clear();
    bq.delete(); oq.delete(); i_addr_q.delete(); d_addr_q.delete();
    m_vld = 0; m_slot = '0; m_lost = 0; i_acc = 0; d_acc = 0;
  endtask

  task automatic drive_inputs();
    logic [31:0] r;
    if (!i_req_valid_i || i_acc) begin
      i_req_valid_i = coin(p_i);
      r = $urandom; i_req_addr_i = r[29:0];
    end
    if (!d_req_valid_i || d_acc) begin
      d_req_valid_i = coin(p_d);
      r = $urandom; d_req_addr_i = r[29:0];
      d_req_wdata_i = $urandom;
      r = $urandom; d_req_wmask_i = r[3:0]; d_req_write_i = r[4];
    end
    i_resp_ready_i  = coin(p_ir);
    d_resp_ready_i  = coin(p_dr);
    mem_req_ready_i = coin(p_mr);
    if (resp_en && bq.size() > 0 && bq[0].age >= bq[0].lat) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_addr_i  = bq[0].addr;
      mem_resp_data_i  = rdata(bq[0].addr);
    end else begin
      mem_resp_valid_i = 1'b0;
      r = $urandom; mem_resp_addr_i = r[29:0];
      mem_resp_data_i = $urandom;
    end
  endtask

  task automatic check_and_step();
    bit slot_free, can, gi, gd, has, own, exp_rr, exp_iv, exp_dv, pop;
    slot_free = !m_vld || mem_req_ready_i;
    can       = slot_free && (oq.size() < MAXO);
    gd        = can && d_req_valid_i && !(i_req_valid_i && m_lost >= LIMIT);
    gi        = can && i_req_valid_i && !gd;
    chk("i_req_ready", i_req_ready_o, gi);
    chk("d_req_ready", d_req_ready_o, gd);
    chk("mem_req_valid", mem_req_valid_o, m_vld);
    if (m_vld) begin
      chk("mem_req_addr", mem_req_addr_o, m_slot.addr);
      chk("mem_req_wdata", mem_req_wdata_o, m_slot.wdata);
      chk("mem_req_wmask", mem_req_wmask_o, m_slot.wmask);
      chk("mem_req_write", mem_req_write_o, m_slot.write);
    end
    has    = oq.size() > 0;
    own    = has ? oq[0] : 1'b0;
    exp_rr = has && (own ? d_resp_ready_i : i_resp_ready_i);
    exp_iv = mem_resp_valid_i && has && !own;
    exp_dv = mem_resp_valid_i && has && own;
    chk("mem_resp_ready", mem_resp_ready_o, exp_rr);
    chk("i_resp_valid", i_resp_valid_o, exp_iv);
    chk("d_resp_valid", d_resp_valid_o, exp_dv);
    if (exp_iv) chk("i_resp_data", i_resp_data_o, rdata(bq[0].addr));
    if (exp_dv) chk("d_resp_data", d_resp_data_o, rdata(bq[0].addr));
    pop = mem_resp_valid_i && exp_rr;
    if (pop) begin
      if (own) chk("d_resp_order", d_resp_addr_o, d_addr_q.pop_front());
      else     chk("i_resp_order", i_resp_addr_o, i_addr_q.pop_front());
      void'(oq.pop_front());
      void'(bq.pop_front());
    end
    foreach (bq[k]) bq[k].age++;
    if (m_vld && mem_req_ready_i)
      bq.push_back('{addr: m_slot.addr, age: 0, lat: $urandom_range(lat_max)});
    if (gi || gd) begin
      m_vld = 1;
      oq.push_back(gd);
      if (gd) begin
        m_slot = '{addr: d_req_addr_i, wdata: d_req_wdata_i, wmask: d_req_wmask_i,
                   write: d_req_write_i};
        d_addr_q.push_back(d_req_addr_i);
      end else begin
        m_slot = '{addr: i_req_addr_i, wdata: '0, wmask: '0, write: 1'b0};
        i_addr_q.push_back(i_req_addr_i);
      end
    end else if (mem_req_ready_i) begin
      m_vld = 0;
    end
    if (gi || !i_req_valid_i) m_lost = 0;
    else if (gd && m_lost < LIMIT) m_lost++;
    i_acc = gi;
    d_acc = gd;
  endtask

  task automatic run_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      drive_inputs();
      @(negedge clk);
      check_and_step();
    end
  endtask

  task automatic set_knobs(input int pi, input int pd, input int pmr, input int pir,
                           input int pdr, input int lm, input bit re);
    p_i = pi; p_d = pd; p_mr = pmr; p_ir = pir; p_dr = pdr; lat_max = lm; resp_en = re;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid_o, 1'b0);
    chk({tag, "_mem_req_addr"}, mem_req_addr_o, '0);
    chk({tag, "_i_req_ready"}, i_req_ready_o, 1'b0);
    chk({tag, "_d_req_ready"}, d_req_ready_o, 1'b0);
    chk({tag, "_i_resp_valid"}, i_resp_valid_o, 1'b0);
    chk({tag, "_d_resp_valid"}, d_resp_valid_o, 1'b0);
    chk({tag, "_mem_resp_ready"}, mem_resp_ready_o, 1'b0);
  endtask

  // Reset asserted between edges with requests pending; the outputs must drop
  // without waiting for a clock edge.
  task automatic mid_reset();
    @(posedge clk); #3;
    i_req_valid_i = 1; d_req_valid_i = 1; mem_req_ready_i = 1;
    i_resp_ready_i = 1; d_resp_ready_i = 1; mem_resp_valid_i = 1;
    rst_ni = 0;
    #1;
    check_reset_outputs("mid_rst");
    model_clear();
    @(posedge clk); @(posedge clk); #3;
    i_req_valid_i = 0; d_req_valid_i = 0; mem_resp_valid_i = 0;
    rst_ni = 1;
  endtask

  initial begin
    model_clear();
    i_req_addr_i = '0; d_req_addr_i = '0; d_req_wdata_i = '0; d_req_wmask_i = '0;
    d_req_write_i = 0; mem_resp_addr_i = '0; mem_resp_data_i = '0;
    i_req_valid_i = 1; d_req_valid_i = 1; mem_req_ready_i = 1;
    i_resp_ready_i = 1; d_resp_ready_i = 1; mem_resp_valid_i = 0;
    rst_ni = 0;
    #2;
    check_reset_outputs("rst");
    @(negedge clk); @(negedge clk); #2;
    i_req_valid_i = 0; d_req_valid_i = 0;
    rst_ni = 1;

    // I only, memory always ready, short latency
    set_knobs(100, 0, 100, 100, 100, 0, 1);
    run_phase(40);
    // I and D both valid every cycle: starvation limit shapes the grant pattern
    set_knobs(100, 100, 100, 100, 100, 0, 1);
    run_phase(60);
    // No responses: FIFO fills, then grants stop
    set_knobs(100, 100, 100, 100, 100, 0, 0);
    run_phase(20);
    // Responses resume one at a time with D owner stalled
    set_knobs(100, 100, 100, 100, 30, 3, 1);
    run_phase(80);
    // Reset with requests in flight, then traffic resumes
    set_knobs(100, 60, 100, 100, 100, 2, 1);
    run_phase(6);
    mid_reset();
    set_knobs(100, 0, 100, 100, 100, 0, 1);
    run_phase(20);
    // Fully random traffic and backpressure
    set_knobs(60, 60, 70, 70, 70, 4, 1);
    run_phase(1500);
    set_knobs(90, 90, 40, 50, 50, 6, 1);
    run_phase(1000);
    mid_reset();
    set_knobs(50, 80, 80, 80, 80, 2, 1);
    run_phase(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
